// File: rtl/led_status_ctrl.sv
// rtl/led_status_ctrl.sv - multi-channel LED status driver with shared prescaler
//
// Purpose:
//   Drives NCH debug LEDs from one shared tick prescaler. Each channel is
//   off, steady on, blinking with the shared blink phase, or showing a
//   retriggerable activity stretch.
//
// Optional feature macro: LED_STATUS_PWM_EN
//   When defined, adds bright_i and a free-running 4-bit PWM counter that
//   gates every lit channel for brightness control.
//
// Ports:
//   clk       single clock, all state on its rising edge
//   rst       asynchronous active-high reset
//   bright_i  [3:0] brightness, 15 = full on (LED_STATUS_PWM_EN only)
//   mode_i    [2*NCH-1:0] per-channel mode at [2k+1:2k]:
//             00 off, 01 on, 10 blink, 11 activity
//   evt_i     [NCH-1:0] per-channel activity strobe
//   led_o     [NCH-1:0] registered LED drive, 1 = lit
//   tick_o    one-cycle pulse per prescaler wrap
//   blink_o   shared blink phase

module led_status_ctrl #(
    parameter int NCH       = 4,
    parameter int PRESC_DIV = 25000000,
    parameter int STRETCH   = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LED_STATUS_PWM_EN
    input  logic [3:0]       bright_i,
`endif
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   evt_i,
    output logic [NCH-1:0]   led_o,
    output logic             tick_o,
    output logic             blink_o
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [PW-1:0] PMAX  = PW'(PRESC_DIV - 1);
    localparam logic [SW-1:0] SLOAD = SW'(STRETCH);

    generate
        if (NCH < 1) begin : g_bad_nch
            $error("led_status_ctrl: NCH must be >= 1");
        end
        if (PRESC_DIV < 1) begin : g_bad_presc
            $error("led_status_ctrl: PRESC_DIV must be >= 1");
        end
        if (STRETCH < 1) begin : g_bad_stretch
            $error("led_status_ctrl: STRETCH must be >= 1");
        end
    endgenerate

    logic [PW-1:0] presc;
    logic [SW-1:0] stretch [NCH];
    logic [NCH-1:0] lit;

    // Prescaler, tick and blink phase. tick_o is registered from the
    // terminal count, so it lands in the cycle after presc == PMAX; with
    // PRESC_DIV=1 presc sits at 0 and tick_o stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            tick_o  <= 1'b0;
            blink_o <= 1'b0;
        end else begin
            tick_o  <= (presc == PMAX);
            presc   <= (presc == PMAX) ? '0 : presc + 1'b1;
            blink_o <= blink_o ^ tick_o;
        end
    end

    // Activity stretch counters run in every mode so a temporary mode change
    // does not lose pending on-time. A new event always wins over a decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                stretch[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (evt_i[k]) begin
                    stretch[k] <= SLOAD;
                end else if (tick_o && (stretch[k] != '0)) begin
                    stretch[k] <= stretch[k] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        lit = '0;
        for (int k = 0; k < NCH; k++) begin
            case (mode_i[2*k +: 2])
                2'b00:   lit[k] = 1'b0;
                2'b01:   lit[k] = 1'b1;
                2'b10:   lit[k] = blink_o;
                default: lit[k] = (stretch[k] != '0);
            endcase
        end
    end

`ifdef LED_STATUS_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    // 15 is treated as full on so the top setting has no dark slot.
    assign pwm_on = (bright_i == 4'hF) || (pwm_cnt < bright_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
            led_o   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_o   <= lit & {NCH{pwm_on}};
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_o <= '0;
        end else begin
            led_o <= lit;
        end
    end
`endif

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb/tb_led_status_ctrl.sv - scoreboard bench for led_status_ctrl

module tb_led_status_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] mode_a, mode_b;
    logic [3:0] evt_a, evt_b;
    logic [3:0] led_a, led_b;
    logic       tick_a, tick_b, blink_a, blink_b;
`ifdef LED_STATUS_PWM_EN
    logic [3:0] bright;
    int         pwm_ones;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acnt     = 0;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] exp;
    } exp_t;
    exp_t q[$];

    led_status_ctrl #(.NCH(4), .PRESC_DIV(8), .STRETCH(3)) dut_a (
        .clk(clk),
        .rst(rst),
`ifdef LED_STATUS_PWM_EN
        .bright_i(bright),
`endif
        .mode_i(mode_a),
        .evt_i(evt_a),
        .led_o(led_a),
        .tick_o(tick_a),
        .blink_o(blink_a)
    );

    led_status_ctrl #(.NCH(4), .PRESC_DIV(1), .STRETCH(3)) dut_b (
        .clk(clk),
        .rst(rst),
`ifdef LED_STATUS_PWM_EN
        .bright_i(bright),
`endif
        .mode_i(mode_b),
        .evt_i(evt_b),
        .led_o(led_b),
        .tick_o(tick_b),
        .blink_o(blink_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // tick_a high after edge c (c edges since release) when c is a multiple of 8
    function automatic logic exp_tick_a(input int c);
        return (c > 0) && (c % 8 == 0);
    endfunction

    // blink_a toggles at edges where tick was high: edges 9, 17, 25, ...
    function automatic logic exp_blink_a(input int c);
        if (c == 0) return 1'b0;
        return 1'(((c - 1) / 8) % 2);
    endfunction

    function automatic logic [7:0] obs(input int s);
        case (s)
            0: return {7'b0, tick_a};
            1: return {7'b0, blink_a};
            2: return {4'b0, led_a};
            3: return {7'b0, tick_b};
            4: return {4'b0, led_b};
            5: return {7'b0, blink_b};
`ifdef LED_STATUS_PWM_EN
            6: return 8'(pwm_ones);
`endif
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.sig = sig;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic check_q();
        exp_t       x;
        logic [7:0] o;
        while (q.size() > 0) begin
            x = q.pop_front();
            o = obs(x.sig);
            checks++;
            assert (o === x.exp) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed=%0h expected=%0h", x.tag, cyc, o, x.exp);
            end
        end
    endtask

    // One clock edge with expectations for both DUTs. DUT a has modes
    // ch0..3 = off/on/blink/activity (ch3 optionally blink); DUT b shows lb.
    task automatic stp(input logic ev_a, input logic ch3_blink, input logic [3:0] lb);
        logic l3;
        int   e;
        evt_a       = {ev_a, 3'b000};
        mode_a[7:6] = ch3_blink ? 2'b10 : 2'b11;
        l3 = ch3_blink ? exp_blink_a(cyc) : (acnt != 0);
        e  = cyc + 1;
        push("led_a", 2, {4'b0, l3, exp_blink_a(cyc), 2'b10});
        push("tick_a", 0, {7'b0, exp_tick_a(e)});
        push("blink_a", 1, {7'b0, exp_blink_a(e)});
        push("led_b", 4, {4'b0, lb});
        push("tick_b", 3, 8'h01);
        push("blink_b", 5, {7'b0, 1'(cyc % 2)});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_q();
        if (ev_a) acnt = 3;
        else if (e > 1 && (e - 1) % 8 == 0 && acnt > 0) acnt--;
    endtask

    initial begin
        rst    = 1'b1;
        mode_a = 8'b11_10_01_00;
        mode_b = 8'hFF;
        evt_a  = 4'h0;
        evt_b  = 4'h0;
`ifdef LED_STATUS_PWM_EN
        bright = 4'hF;
`endif
        repeat (2) @(negedge clk);

        // reset state
        push("rst_tick_a", 0, 8'h00);
        push("rst_blink_a", 1, 8'h00);
        push("rst_led_a", 2, 8'h00);
        push("rst_tick_b", 3, 8'h00);
        push("rst_led_b", 4, 8'h00);
        push("rst_blink_b", 5, 8'h00);
        check_q();

        rst = 1'b0;
        cyc = 0;
        acnt = 0;

        // prescaler, blink period and static modes
        for (int i = 0; i < 34; i++) stp(1'b0, 1'b0, 4'h0);

        // single activity pulse on DUT b (PRESC_DIV=1): lit exactly 3 cycles
        evt_b = 4'h1; stp(1'b0, 1'b0, 4'h0);
        evt_b = 4'h0; stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h0);
        stp(1'b0, 1'b0, 4'h0);

        // retrigger at N and N+2: lit N+1..N+5
        evt_b = 4'h1; stp(1'b0, 1'b0, 4'h0);
        evt_b = 4'h0; stp(1'b0, 1'b0, 4'h1);
        evt_b = 4'h1; stp(1'b0, 1'b0, 4'h1);
        evt_b = 4'h0; stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h1);
        stp(1'b0, 1'b0, 4'h0);

        // DUT a activity, a mode 11 -> 10 -> 11 hop keeps the counter
        stp(1'b1, 1'b0, 4'h0);
        stp(1'b0, 1'b0, 4'h0);
        stp(1'b0, 1'b1, 4'h0);
        stp(1'b0, 1'b0, 4'h0);

        // continuous events keep ch3 lit, then decay over the tick grid
        for (int i = 0; i < 40; i++) stp(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 30; i++) stp(1'b0, 1'b0, 4'h0);

        // load stretch counters, then reset asynchronously mid-cycle with blink high
        evt_b = 4'h1;
        stp(1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 20 && exp_blink_a(cyc) != 1'b1; k++) stp(1'b1, 1'b0, 4'h1);
        evt_a = 4'h0;
        evt_b = 4'h0;
        #2 rst = 1'b1;
        #1;
        push("arst_led_a", 2, 8'h00);
        push("arst_tick_a", 0, 8'h00);
        push("arst_blink_a", 1, 8'h00);
        push("arst_led_b", 4, 8'h00);
        push("arst_tick_b", 3, 8'h00);
        push("arst_blink_b", 5, 8'h00);
        check_q();
        @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        acnt = 0;
        for (int i = 0; i < 12; i++) stp(1'b0, 1'b0, 4'h0);

`ifdef LED_STATUS_PWM_EN
        // brightness: count lit cycles of steady-on ch1 over one PWM period
        for (int v = 0; v < 3; v++) begin
            bright   = (v == 0) ? 4'd4 : (v == 1) ? 4'd0 : 4'd15;
            pwm_ones = 0;
            push("pwm_ones", 6, (v == 0) ? 8'd4 : (v == 1) ? 8'd0 : 8'd16);
            for (int i = 0; i < 16; i++) begin
                @(posedge clk);
                @(negedge clk);
                pwm_ones += int'(led_a[1]);
            end
            check_q();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
